uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | uart_rx : 16x-oversampled UART receiver, LSB first, single-word holding reg |
// | Optional even parity bit when UART_RX_PARITY_EN is defined.                 |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_en,
  input  logic              rx_tick,
  input  logic              rx_in,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
`ifdef UART_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              overrun_err
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd4;
`endif

  logic              r_sync1;
  logic              r_sync2;
  logic [2:0]        r_state;
  logic [3:0]        r_tick_cnt;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;

  logic w_mid_start;
  logic w_bit_end;
  logic w_last_bit;
  logic w_stop_evt;
  logic w_par_ok;
  logic w_good;

  assign w_mid_start = (r_tick_cnt == 4'd7);
  assign w_bit_end   = (r_tick_cnt == 4'd15);
  assign w_last_bit  = (r_bit_cnt == 3'(DATA_W - 1));
  assign w_stop_evt  = uart_en && rx_tick && (r_state == c_STOP) && w_bit_end;
  assign w_good      = w_stop_evt && r_sync2 && w_par_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_bit <= 1'b0;
    end else if (!uart_en) begin
      r_par_bit <= 1'b0;
    end else if (rx_tick && (r_state == c_PARITY) && w_bit_end) begin
      r_par_bit <= r_sync2;
    end
  end

  // Even parity: data plus parity bit carry an even number of ones.
  assign w_par_ok = ~(^{r_shift, r_par_bit});
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= '0;
    end else if (!uart_en) begin
      r_state    <= c_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= '0;
    end else if (rx_tick) begin
      case (r_state)
        c_IDLE: begin
          if (!r_sync2) begin
            r_state    <= c_START;
            r_tick_cnt <= 4'd0;
          end
        end
        c_START: begin
          if (w_mid_start) begin
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_state    <= r_sync2 ? c_IDLE : c_DATA;
          end else begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        // Tick counter wraps 15 -> 0, so each sample lands 16 ticks after the last.
        c_DATA: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) begin
            r_shift <= {r_sync2, r_shift[DATA_W-1:1]};
            if (w_last_bit) begin
              r_bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
              r_state   <= c_PARITY;
`else
              r_state   <= c_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        c_PARITY: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) r_state <= c_STOP;
        end
`endif
        c_STOP: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) r_state <= c_IDLE;
        end
        default: begin
          r_state    <= c_IDLE;
          r_tick_cnt <= 4'd0;
        end
      endcase
    end
  end

  // A completing frame may reuse the holding register only if it is free or being acked now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_stop_evt && !r_sync2;
      overrun_err <= w_good && rx_valid && !rx_ack;
      if (w_good && (!rx_valid || rx_ack)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= w_stop_evt && !w_par_ok;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for uart_rx: vector table plus hand-written corner sequences.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_en = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic       rx_tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       tb_par_flip = 1'b0;
  int         perr_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] cyc = 32'd0;
  int          nticks = 0;
  int          last_stop_start = 0;

  uart_rx #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_en     (uart_en),
    .rx_tick     (rx_tick),
    .rx_in       (rx_in),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  // One oversample strobe every 4 clocks.
  assign rx_tick = (cyc[1:0] == 2'd0);

  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (rx_tick) nticks <= nticks + 1;
  end

  // Output monitor: a word is produced when rx_valid rises or rx_data changes while valid.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         rise_tick = 0;
  logic [1:0] rise_phase = 2'd0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    prev_data  <= rx_data;
    if (rx_valid && (!prev_valid || rx_data != prev_data)) got_q.push_back(rx_data);
    if (rx_valid && !prev_valid) begin
      rise_tick  <= nticks;
      rise_phase <= cyc[1:0];
    end
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (overrun_err) ovr_cnt  <= ovr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err)  perr_cnt <= perr_cnt + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    int guard;
    t0 = nticks;
    guard = 0;
    while (nticks - t0 < n) begin
      @(negedge clk);
      guard++;
      if (guard > 8 * n + 16) begin
        checks++;
        failures++;
        $display("FAIL tick_timeout: got %0d ticks expected %0d", nticks - t0, n);
        return;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(16);
  endtask

  // Start edge is always launched right after a tick, so the DUT samples each bit 9 ticks in.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_at_stop);
    wait_ticks(1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ tb_par_flip);
`endif
    rx_in = stop;
    last_stop_start = nticks;
    if (ack_at_stop) begin
      wait_ticks(8);
      repeat (3) @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      wait_ticks(3);
    end else begin
      wait_ticks(12);
    end
    rx_in = 1'b1;
    wait_ticks(20);
  endtask

  task automatic sb_drain(input string name);
    logic [7:0] g;
    logic [7:0] e;
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_word"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int o0;
`ifdef UART_RX_PARITY_EN
    int p0;
`endif
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 0};

    repeat (4) @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun_err, 0);
    rst = 1'b1;
    uart_en = 1'b1;
    wait_ticks(4);

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), rx_data, vecs[i].data);
        check($sformatf("vec%0d_rise_tick", i), rise_tick - last_stop_start, 9);
        check($sformatf("vec%0d_rise_phase", i), rise_phase, 1);
      end
      sb_drain($sformatf("vec%0d", i));
      if (vecs[i].exp_valid) begin
        do_ack();
        check($sformatf("vec%0d_ack_clear", i), rx_valid, 0);
      end
    end

    // Short start pulse is rejected silently, and the next frame is still received.
    f0 = ferr_cnt;
    wait_ticks(1);
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(30);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_loads", got_q.size(), 0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b0);
    sb_drain("post_glitch");
    do_ack();

    // Overrun: second word is dropped while the first is unacknowledged.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    o0 = ovr_cnt;
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1);
    sb_drain("ovr");
    do_ack();

    // Ack coincident with completion: new word replaces old, no overrun.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    exp_q.push_back(8'h22);
    o0 = ovr_cnt;
    send_frame(8'h22, 1'b1, 1'b1);
    check("coinc_ovr", ovr_cnt - o0, 0);
    check("coinc_data", rx_data, 8'h22);
    check("coinc_valid", rx_valid, 1);
    sb_drain("coinc");
    do_ack();
    do_ack();
    check("idle_ack_valid", rx_valid, 0);
    check("idle_ack_data", rx_data, 8'h22);

    // Receiver disabled mid-frame: partial frame must leave no trace.
    f0 = ferr_cnt;
    wait_ticks(1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    uart_en = 1'b0;
    rx_in = 1'b1;
    wait_ticks(5);
    uart_en = 1'b1;
    wait_ticks(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("en_loads", got_q.size(), 1);
    check("en_ferr", ferr_cnt - f0, 0);
    sb_drain("en");
    do_ack();

    // Reset mid-frame aborts the frame; receiver restarts cleanly.
    f0 = ferr_cnt;
    wait_ticks(1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    rx_in = 1'b1;
    wait_ticks(2);
    check("rst_mid_data", rx_data, 0);
    check("rst_mid_valid", rx_valid, 0);
    rst = 1'b1;
    wait_ticks(20);
    check("rst_mid_loads", got_q.size(), 0);
    check("rst_mid_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    sb_drain("post_rst");
    do_ack();

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    tb_par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    tb_par_flip = 1'b0;
    check("par_bad_pulse", perr_cnt - p0, 1);
    check("par_bad_valid", rx_valid, 0);
    check("par_bad_loads", got_q.size(), 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_good_data", rx_data, 8'h07);
    sb_drain("par_good");
    do_ack();
`endif

    check("final_exp_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
